aux_cmd_driver: RTL and testbench
=================================

AUX_CMD_DRIVER -- requirements
Module: aux_cmd_driver

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 2, cycles that AUX fields are stable before a strobe.
REQ-002 SHALL have parameter HOLD_CYCLES, default 2, cycles that AUX fields are held after a strobe, or before a read sample.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum wait for the core interrupt.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  driver accepts a command this cycle.
REQ-008 cmd_op  input  2  0=WRITE, 1=LOAD, 2=MATMUL, 3=READ.
REQ-009 cmd_idx  input  3  element index.
REQ-010 cmd_reg  input  4  register select.
REQ-011 cmd_data  input  8  write data.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  response consumed.
REQ-014 rsp_data  output  8  sampled core data (READ only, else 0).
REQ-015 rsp_err  output  1  interrupt timeout occurred.
REQ-016 core_en  output  1  core enable.
REQ-017 aux  output  9  to core: [0]=write, [1]=load, [4:2]=idx, [8:5]=reg_select.
REQ-018 core_data_in  output  8  write data to core.
REQ-019 core_data_out  input  8  read data from core.
REQ-020 core_irq  input  1  core completion interrupt, level.

Function
REQ-021 SHALL implement states IDLE, SETUP, STROBE, HOLD, WAIT_IRQ, RESP.
REQ-022 cmd_ready SHALL be 1 only in IDLE; acceptance when cmd_valid&&cmd_ready registers op/idx/reg/data and moves to SETUP.
REQ-023 SETUP: aux[8:2]=latched idx/reg, core_data_in=latched data, aux[1:0]=0, for exactly SETUP_CYCLES cycles; SETUP_CYCLES=0 SHALL go straight to STROBE.
REQ-024 STROBE lasts exactly 1 cycle: WRITE sets aux[0]=1; LOAD sets aux[1]=1; MATMUL sets aux[1:0]=2'b11; READ sets no strobe.
REQ-025 HOLD: aux fields unchanged, strobes 0, for HOLD_CYCLES cycles; READ SHALL sample core_data_out on the last HOLD cycle into rsp_data.
REQ-026 After HOLD, MATMUL SHALL enter WAIT_IRQ; all others enter RESP.
REQ-027 WAIT_IRQ SHALL detect a rising edge of core_irq (registered previous value), then enter RESP with rsp_err=0.
REQ-028 An irq already high on entry to WAIT_IRQ SHALL not count; a new 0->1 edge is required.
REQ-029 RESP: rsp_valid=1 with rsp_data/rsp_err stable until rsp_ready; the handshake cycle returns to IDLE; no new command is accepted in that cycle.
REQ-030 core_en SHALL be 1 in every state except reset.
REQ-031 aux and core_data_in SHALL hold their last values in IDLE; strobe bits SHALL be 0 outside STROBE.
REQ-032 Cycle counter SHALL be sized for max(SETUP_CYCLES,HOLD_CYCLES,TIMEOUT_CYCLES) and SHALL not wrap.

Reset
REQ-033 rst SHALL force IDLE, cmd_ready=1 on the following cycle, rsp_valid=0, rsp_data=0, rsp_err=0, aux=0, core_data_in=0, core_en=0, counter=0.
REQ-034 rst mid-command SHALL abandon the command with no response.
REQ-035 rst SHALL override all other inputs in the same cycle.

Configuration
REQ-036 With AUX_TIMEOUT_EN defined, WAIT_IRQ SHALL exit to RESP with rsp_err=1 after TIMEOUT_CYCLES cycles without an edge.
REQ-037 An edge on the same cycle as the timeout SHALL win, giving rsp_err=0.
REQ-038 Without AUX_TIMEOUT_EN, WAIT_IRQ SHALL wait indefinitely, and rsp_err SHALL be tied 0.

Structure
REQ-039 Shared package aux_pkg SHALL hold the opcode enum, the state enum, and AUX bit-position constants (WR_BIT=0, LD_BIT=1, IDX_LSB=2, REG_LSB=5).
REQ-040 Single module, with no sub-modules.

Verification
REQ-041 WRITE idx=3 reg=5 data=0xA5: aux[8:2]={5,3} for 2 cycles, then aux[0]=1 for 1 cycle, then held 2 cycles; core_data_in=0xA5; then rsp_valid with rsp_err=0.
REQ-042 READ reg=2 idx=1, core_data_out=0x3C: no strobe; rsp_data=0x3C.
REQ-043 MATMUL, irq rising 10 cycles after HOLD: aux[1:0]=11 for one cycle; rsp_valid 1 cycle after the edge, rsp_err=0.
REQ-044 MATMUL, no irq, AUX_TIMEOUT_EN, TIMEOUT_CYCLES=16: rsp_err=1 after 16 WAIT_IRQ cycles.
REQ-045 rsp_ready held 0 for 5 cycles: rsp_valid and rsp_data stable; cmd_ready=0 throughout.
REQ-046 rst asserted during STROBE of a LOAD: next cycle aux=0, no rsp_valid; a following WRITE completes normally.

Source files
------------

// File: rtl/aux_pkg.sv
// Shared types and AUX bus bit positions for the aux command driver.
package aux_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_LOAD   = 2'd1,
    OP_MATMUL = 2'd2,
    OP_READ   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_STROBE   = 3'd2,
    ST_HOLD     = 3'd3,
    ST_WAIT_IRQ = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

  localparam int WR_BIT  = 0;
  localparam int LD_BIT  = 1;
  localparam int IDX_LSB = 2;
  localparam int REG_LSB = 5;

endpackage

// File: rtl/aux_cmd_driver.sv
// Sequences one command at a time onto the core AUX bus with setup/strobe/hold timing.
// Optional macro AUX_TIMEOUT_EN adds a WAIT_IRQ timeout that reports rsp_err=1.
module aux_cmd_driver
  import aux_pkg::*;
#(
  parameter int SETUP_CYCLES   = 2,
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_idx,
  input  logic [3:0] cmd_reg,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       core_en,
  output logic [8:0] aux,
  output logic [7:0] core_data_in,
  input  logic [7:0] core_data_out,
  input  logic       core_irq
);

  localparam int MAX_SH = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MAX_CNT = (MAX_SH > TIMEOUT_CYCLES) ? MAX_SH : TIMEOUT_CYCLES;
  localparam int CNT_W = ($clog2(MAX_CNT + 1) > 0) ? $clog2(MAX_CNT + 1) : 1;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

  state_e           r_state;
  state_e           w_next;
  state_e           w_after_hold;
  logic [CNT_W-1:0] r_cnt;
  op_e              r_op;
  logic [2:0]       r_idx;
  logic [3:0]       r_reg;
  logic [7:0]       r_data;
  logic [7:0]       r_rsp_data;
  logic             r_irq_prev;
  logic             r_core_en;
  logic             w_accept;
  logic             w_edge;
  logic             w_read_sample;
  logic             w_count;

  assign w_accept     = cmd_valid && (r_state == ST_IDLE);
  assign w_edge       = core_irq && !r_irq_prev;
  assign w_after_hold = (r_op == OP_MATMUL) ? ST_WAIT_IRQ : ST_RESP;
  // With no hold window the read sample falls on the strobe cycle instead.
  assign w_read_sample = (r_op == OP_READ) &&
                         (((r_state == ST_HOLD) && (r_cnt == HOLD_LAST)) ||
                          ((HOLD_CYCLES == 0) && (r_state == ST_STROBE)));

`ifdef AUX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic r_rsp_err;
  logic w_timeout;
  assign w_timeout = (r_state == ST_WAIT_IRQ) && !w_edge && (r_cnt == TIMEOUT_LAST);
  assign rsp_err   = r_rsp_err;
`else
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    aux       = '0;
    aux[IDX_LSB +: 3] = r_idx;
    aux[REG_LSB +: 4] = r_reg;
    unique case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (w_accept) w_next = (SETUP_CYCLES == 0) ? ST_STROBE : ST_SETUP;
      end
      ST_SETUP: if (r_cnt == SETUP_LAST) w_next = ST_STROBE;
      ST_STROBE: begin
        aux[WR_BIT] = (r_op == OP_WRITE) || (r_op == OP_MATMUL);
        aux[LD_BIT] = (r_op == OP_LOAD)  || (r_op == OP_MATMUL);
        w_next = (HOLD_CYCLES == 0) ? w_after_hold : ST_HOLD;
      end
      ST_HOLD: if (r_cnt == HOLD_LAST) w_next = w_after_hold;
      ST_WAIT_IRQ: begin
        if (w_edge) w_next = ST_RESP;
`ifdef AUX_TIMEOUT_EN
        else if (w_timeout) w_next = ST_RESP;
`endif
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // The counter restarts on every state change, so it never passes the
  // current state's terminal count and cannot wrap.
`ifdef AUX_TIMEOUT_EN
  assign w_count = (r_state == ST_SETUP) || (r_state == ST_HOLD) || (r_state == ST_WAIT_IRQ);
`else
  assign w_count = (r_state == ST_SETUP) || (r_state == ST_HOLD);
`endif

  always_ff @(posedge clk) begin
    if (rst)                    r_cnt <= '0;
    else if (w_next != r_state) r_cnt <= '0;
    else if (w_count)           r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= OP_WRITE;
      r_idx      <= '0;
      r_reg      <= '0;
      r_data     <= '0;
      r_rsp_data <= '0;
      r_irq_prev <= 1'b0;
      r_core_en  <= 1'b0;
`ifdef AUX_TIMEOUT_EN
      r_rsp_err  <= 1'b0;
`endif
    end else begin
      r_core_en  <= 1'b1;
      r_irq_prev <= core_irq;
      if (w_accept) begin
        r_op       <= op_e'(cmd_op);
        r_idx      <= cmd_idx;
        r_reg      <= cmd_reg;
        r_data     <= cmd_data;
        r_rsp_data <= '0;
`ifdef AUX_TIMEOUT_EN
        r_rsp_err  <= 1'b0;
`endif
      end
      if (w_read_sample) r_rsp_data <= core_data_out;
`ifdef AUX_TIMEOUT_EN
      if (w_timeout) r_rsp_err <= 1'b1;
`endif
    end
  end

  assign core_en      = r_core_en;
  assign core_data_in = r_data;
  assign rsp_data     = r_rsp_data;

endmodule

// File: tb/tb_aux_cmd_driver.sv
// Directed self-checking bench for aux_cmd_driver (default timing, TIMEOUT_CYCLES=16).
module tb_aux_cmd_driver;

  localparam int SETUP = 2;
  localparam int HOLD  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmdValid;
  logic       cmdReady;
  logic [1:0] cmdOp;
  logic [2:0] cmdIdx;
  logic [3:0] cmdReg;
  logic [7:0] cmdData;
  logic       rspValid;
  logic       rspReady;
  logic [7:0] rspData;
  logic       rspErr;
  logic       coreEn;
  logic [8:0] aux;
  logic [7:0] coreDataIn;
  logic [7:0] coreDataOut;
  logic       coreIrq;

  int compareCount = 0;
  int failCount    = 0;

  aux_cmd_driver #(
    .SETUP_CYCLES  (SETUP),
    .HOLD_CYCLES   (HOLD),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmdValid),
    .cmd_ready    (cmdReady),
    .cmd_op       (cmdOp),
    .cmd_idx      (cmdIdx),
    .cmd_reg      (cmdReg),
    .cmd_data     (cmdData),
    .rsp_valid    (rspValid),
    .rsp_ready    (rspReady),
    .rsp_data     (rspData),
    .rsp_err      (rspErr),
    .core_en      (coreEn),
    .aux          (aux),
    .core_data_in (coreDataIn),
    .core_data_out(coreDataOut),
    .core_irq     (coreIrq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offers one command in IDLE; returns sampled in the first SETUP cycle.
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] idx,
                               input logic [3:0] rg, input logic [7:0] data);
    cmdOp    = op;
    cmdIdx   = idx;
    cmdReg   = rg;
    cmdData  = data;
    cmdValid = 1'b1;
    checkOutput("cmd_ready_idle", {31'd0, cmdReady}, 32'd1);
    tick();
    cmdValid = 1'b0;
    checkOutput("cmd_ready_busy", {31'd0, cmdReady}, 32'd0);
  endtask

  // Runs a command through SETUP/STROBE/HOLD, ending sampled one cycle past HOLD.
  task automatic runCommand(input logic [1:0] op, input logic [2:0] idx, input logic [3:0] rg,
                            input logic [7:0] data, input logic [1:0] strobe);
    logic [8:0] base;
    base = {rg, idx, 2'b00};
    applyStimulus(op, idx, rg, data);
    for (int i = 0; i < SETUP; i++) begin
      checkOutput("aux_setup", {23'd0, aux}, {23'd0, base});
      checkOutput("data_in", {24'd0, coreDataIn}, {24'd0, data});
      tick();
    end
    checkOutput("aux_strobe", {23'd0, aux}, {23'd0, base | {7'd0, strobe}});
    tick();
    for (int i = 0; i < HOLD; i++) begin
      checkOutput("aux_hold", {23'd0, aux}, {23'd0, base});
      tick();
    end
  endtask

  task automatic handshake();
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    checkOutput("rsp_valid_done", {31'd0, rspValid}, 32'd0);
    checkOutput("cmd_ready_after", {31'd0, cmdReady}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; cmdValid = 1'b0; cmdOp = '0; cmdIdx = '0; cmdReg = '0; cmdData = '0;
    rspReady = 1'b0; coreDataOut = '0; coreIrq = 1'b0;
    tick();
    tick();
    checkOutput("rst_cmd_ready", {31'd0, cmdReady}, 32'd1);
    checkOutput("rst_rsp_valid", {31'd0, rspValid}, 32'd0);
    checkOutput("rst_aux", {23'd0, aux}, 32'd0);
    checkOutput("rst_data_in", {24'd0, coreDataIn}, 32'd0);
    checkOutput("rst_core_en", {31'd0, coreEn}, 32'd0);
    checkOutput("rst_rsp", {23'd0, rspErr, rspData}, 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("core_en_run", {31'd0, coreEn}, 32'd1);

    // READ reg=2 idx=1: no strobe bits, rsp_data sampled from the core
    coreDataOut = 8'h3C;
    runCommand(2'd3, 3'd1, 4'd2, 8'h00, 2'b00);
    coreDataOut = 8'h00;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", {31'd0, rspValid}, 32'd1);
      checkOutput("stall_data", {24'd0, rspData}, 32'h3C);
      checkOutput("stall_cmd_ready", {31'd0, cmdReady}, 32'd0);
      cmdValid = 1'b1;
      tick();
    end
    cmdValid = 1'b0;
    handshake();
    checkOutput("idle_aux_held", {23'd0, aux}, 32'h044);

    // WRITE idx=3 reg=5 data=0xA5
    runCommand(2'd0, 3'd3, 4'd5, 8'hA5, 2'b01);
    checkOutput("wr_rsp_valid", {31'd0, rspValid}, 32'd1);
    checkOutput("wr_rsp_err", {31'd0, rspErr}, 32'd0);
    checkOutput("wr_rsp_data", {24'd0, rspData}, 32'd0);
    handshake();
    checkOutput("idle_aux_wr", {23'd0, aux}, 32'h0AC);
    checkOutput("idle_data_wr", {24'd0, coreDataIn}, 32'hA5);

    // MATMUL with irq already high on entry, then a fresh edge 10 cycles in
    coreIrq = 1'b1;
    runCommand(2'd2, 3'd0, 4'd1, 8'h11, 2'b11);
    for (int i = 0; i < 4; i++) begin
      checkOutput("mm_wait_high", {31'd0, rspValid}, 32'd0);
      tick();
    end
    coreIrq = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checkOutput("mm_wait_low", {31'd0, rspValid}, 32'd0);
      tick();
    end
    coreIrq = 1'b1;
    checkOutput("mm_edge_cycle", {31'd0, rspValid}, 32'd0);
    tick();
    checkOutput("mm_rsp_valid", {31'd0, rspValid}, 32'd1);
    checkOutput("mm_rsp_err", {31'd0, rspErr}, 32'd0);
    handshake();
    coreIrq = 1'b0;

    // MATMUL with no irq: timeout build errors out after 16 cycles
    runCommand(2'd2, 3'd2, 4'd3, 8'h22, 2'b11);
`ifdef AUX_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    checkOutput("to_before", {31'd0, rspValid}, 32'd0);
    tick();
    checkOutput("to_valid", {31'd0, rspValid}, 32'd1);
    checkOutput("to_err", {31'd0, rspErr}, 32'd1);
    handshake();
`else
    for (int i = 0; i < 30; i++) tick();
    checkOutput("nto_waiting", {31'd0, rspValid}, 32'd0);
    coreIrq = 1'b1;
    tick();
    checkOutput("nto_valid", {31'd0, rspValid}, 32'd1);
    checkOutput("nto_err", {31'd0, rspErr}, 32'd0);
    handshake();
    coreIrq = 1'b0;
`endif

    // Reset during the strobe of a LOAD abandons it
    applyStimulus(2'd1, 3'd7, 4'd15, 8'h5A);
    tick();
    tick();
    checkOutput("ld_strobe", {23'd0, aux}, 32'h1FE);
    rst = 1'b1;
    rspReady = 1'b1;
    tick();
    rst = 1'b0;
    rspReady = 1'b0;
    checkOutput("ld_rst_aux", {23'd0, aux}, 32'd0);
    checkOutput("ld_rst_data", {24'd0, coreDataIn}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("ld_no_rsp", {31'd0, rspValid}, 32'd0);
      tick();
    end
    runCommand(2'd0, 3'd4, 4'd9, 8'h7E, 2'b01);
    checkOutput("post_rst_valid", {31'd0, rspValid}, 32'd1);
    checkOutput("post_rst_err", {31'd0, rspErr}, 32'd0);
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
